// File: rtl/irq_entry_sequencer.sv
// irq_entry_sequencer: runs the interrupt entry handshake with the core, computes handler vectors,
// pulses source clears and tracks in-service state with one level of nvIRQ-over-vectored nesting.
module irq_entry_sequencer #(
    parameter logic [31:0] VECTOR_BASE = 32'h0000_0040,
    parameter int unsigned STRIDE_LOG2 = 2,
    parameter logic [31:0] NV_VECTOR   = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wire_VICIRQRequest,
    input  logic [3:0]  wire_IRQArbiter_HandlerNum,
    input  logic        wire_IRQArbiter_IsnvIRQ,
    input  logic        cpu_irq_enable,
    input  logic        cpu_ack,
    input  logic        cpu_eoi,
    output logic        irq_take,
    output logic [31:0] irq_vector,
    output logic [15:0] vIRQClear,
    output logic        nvIRQClear,
    output logic        in_service,
    output logic        in_service_nv,
    output logic [3:0]  active_num
);
    typedef enum logic [1:0] {IDLE, TAKE, SERVICE} state_t;
    state_t state, stateNext;
    logic curNv, curNvNext, nestValid, nestValidNext, ackPulse;
    logic [3:0] curNum, curNumNext, savedNum, savedNumNext;
    logic [31:0] vecAddr;
    always_comb begin
        stateNext = state;
        curNvNext = curNv;
        curNumNext = curNum;
        nestValidNext = nestValid;
        savedNumNext = savedNum;
        ackPulse = 1'b0;
        case (state)
            IDLE: if (wire_VICIRQRequest && cpu_irq_enable) begin
                curNvNext = wire_IRQArbiter_IsnvIRQ;
                curNumNext = wire_IRQArbiter_HandlerNum;
                stateNext = TAKE;
            end
            TAKE: if (cpu_ack) begin
                ackPulse = 1'b1;
                stateNext = SERVICE;
            end
            SERVICE: if (cpu_eoi) begin
                // eoi wins over a simultaneous preemption; the nvIRQ is retaken from IDLE
                if (nestValid) begin
                    curNvNext = 1'b0;
                    curNumNext = savedNum;
                    nestValidNext = 1'b0;
                end else begin
                    stateNext = IDLE;
                end
            end else if (!curNv && wire_VICIRQRequest && wire_IRQArbiter_IsnvIRQ && cpu_irq_enable) begin
                nestValidNext = 1'b1;
                savedNumNext = curNum;
                curNvNext = 1'b1;
                stateNext = TAKE;
            end
            default: stateNext = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            curNv <= 1'b0;
            curNum <= 4'd0;
            nestValid <= 1'b0;
            savedNum <= 4'd0;
            vIRQClear <= 16'd0;
            nvIRQClear <= 1'b0;
        end else begin
            state <= stateNext;
            curNv <= curNvNext;
            curNum <= curNumNext;
            nestValid <= nestValidNext;
            savedNum <= savedNumNext;
            vIRQClear <= (ackPulse && !curNv) ? 16'b1 << curNum : 16'd0;
            nvIRQClear <= ackPulse && curNv;
        end
    end
    assign vecAddr = curNv ? NV_VECTOR : VECTOR_BASE + ({28'b0, curNum} << STRIDE_LOG2);
    assign irq_take = state == TAKE;
    assign irq_vector = irq_take ? vecAddr : 32'd0;
    assign in_service = state == SERVICE || (state == TAKE && nestValid);
    assign in_service_nv = curNv && state == SERVICE;
    assign active_num = nestValid ? savedNum : curNum;
endmodule

// File: tb/tb_irq_entry_sequencer.sv
// tb_irq_entry_sequencer: directed vectors with hand-computed expectations for irq_entry_sequencer.
module tb_irq_entry_sequencer;
    logic clk = 1'b0;
    logic rst, req, isNv, enable, ack, eoi;
    logic [3:0] num;
    logic irqTake, nvClear, inService, inServiceNv;
    logic [31:0] irqVector;
    logic [15:0] vClear;
    logic [3:0] activeNum;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    irq_entry_sequencer dut (
        .clk(clk), .rst(rst),
        .wire_VICIRQRequest(req), .wire_IRQArbiter_HandlerNum(num), .wire_IRQArbiter_IsnvIRQ(isNv),
        .cpu_irq_enable(enable), .cpu_ack(ack), .cpu_eoi(eoi),
        .irq_take(irqTake), .irq_vector(irqVector), .vIRQClear(vClear), .nvIRQClear(nvClear),
        .in_service(inService), .in_service_nv(inServiceNv), .active_num(activeNum)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        check({tag, ".take"}, 32'(irqTake), 32'd0);
        check({tag, ".vec"}, irqVector, 32'd0);
        check({tag, ".vclr"}, 32'(vClear), 32'd0);
        check({tag, ".nvclr"}, 32'(nvClear), 32'd0);
        check({tag, ".insvc"}, 32'(inService), 32'd0);
        check({tag, ".insvcnv"}, 32'(inServiceNv), 32'd0);
        check({tag, ".active"}, 32'(activeNum), 32'd0);
    endtask

    initial begin
        rst = 1; req = 0; isNv = 0; enable = 0; ack = 0; eoi = 0; num = 0;
        tick(); tick();
        rst = 0;
        checkIdle("reset");

        // vectored 5, ack three cycles after take
        enable = 1; num = 5; req = 1;
        tick(); req = 0;
        check("t1.take", 32'(irqTake), 32'd1);
        check("t1.vec", irqVector, 32'h54);
        tick(); tick();
        check("t1.take_hold", 32'(irqTake), 32'd1);
        ack = 1; tick(); ack = 0;
        check("t1.take_off", 32'(irqTake), 32'd0);
        check("t1.vclr", 32'(vClear), 32'h0020);
        check("t1.insvc", 32'(inService), 32'd1);
        check("t1.active", 32'(activeNum), 32'd5);
        tick();
        check("t1.vclr_once", 32'(vClear), 32'd0);
        eoi = 1; tick(); eoi = 0;
        check("t1.eoi", 32'(inService), 32'd0);

        // nvIRQ from idle, vectored request ignored during its service
        req = 1; isNv = 1;
        tick(); req = 0; isNv = 0;
        check("t2.take", 32'(irqTake), 32'd1);
        check("t2.vec", irqVector, 32'h20);
        ack = 1; tick(); ack = 0;
        check("t2.nvclr", 32'(nvClear), 32'd1);
        check("t2.vclr", 32'(vClear), 32'd0);
        check("t2.insvcnv", 32'(inServiceNv), 32'd1);
        req = 1; num = 7;
        tick();
        check("t2.nvclr_once", 32'(nvClear), 32'd0);
        check("t2.no_take", 32'(irqTake), 32'd0);
        tick();
        check("t2.no_take2", 32'(irqTake), 32'd0);
        req = 0; eoi = 1; tick(); eoi = 0;
        check("t2.eoi", 32'(inService), 32'd0);

        // vectored 8 preempted by nvIRQ
        req = 1; num = 8;
        tick(); req = 0;
        ack = 1; tick(); ack = 0;
        check("t3.vclr", 32'(vClear), 32'h0100);
        tick();
        req = 1; isNv = 1;
        tick(); req = 0; isNv = 0;
        check("t3.take", 32'(irqTake), 32'd1);
        check("t3.vec", irqVector, 32'h20);
        check("t3.active", 32'(activeNum), 32'd8);
        check("t3.insvc", 32'(inService), 32'd1);
        ack = 1; tick(); ack = 0;
        check("t3.nvclr", 32'(nvClear), 32'd1);
        check("t3.insvcnv", 32'(inServiceNv), 32'd1);
        tick();
        eoi = 1; tick(); eoi = 0;
        check("t3.eoi1_nv", 32'(inServiceNv), 32'd0);
        check("t3.eoi1_insvc", 32'(inService), 32'd1);
        check("t3.eoi1_active", 32'(activeNum), 32'd8);
        check("t3.eoi1_vclr", 32'(vClear), 32'd0);
        check("t3.eoi1_take", 32'(irqTake), 32'd0);
        eoi = 1; tick(); eoi = 0;
        check("t3.eoi2", 32'(inService), 32'd0);

        // arbiter change during TAKE is ignored
        req = 1; num = 3;
        tick();
        check("t4.vec", irqVector, 32'h4C);
        num = 9; tick(); req = 0;
        check("t4.vec_hold", irqVector, 32'h4C);
        ack = 1; tick(); ack = 0;
        check("t4.vclr", 32'(vClear), 32'h0008);
        eoi = 1; tick(); eoi = 0;

        // enable gating, then ack+eoi together in TAKE
        enable = 0; req = 1; num = 2;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t5.gated", 32'(irqTake), 32'd0);
        end
        enable = 1; tick(); req = 0;
        check("t5.take", 32'(irqTake), 32'd1);
        check("t5.vec", irqVector, 32'h48);
        ack = 1; eoi = 1; tick(); ack = 0; eoi = 0;
        check("t5.ackeoi", 32'(inService), 32'd1);
        check("t5.vclr", 32'(vClear), 32'h0004);
        // eoi with simultaneous nvIRQ: eoi first, nvIRQ taken from IDLE next
        req = 1; isNv = 1; eoi = 1; tick(); eoi = 0;
        check("t5.eoi_first", 32'(inService), 32'd0);
        check("t5.eoi_notake", 32'(irqTake), 32'd0);
        tick(); req = 0; isNv = 0;
        check("t5.nv_take", 32'(irqTake), 32'd1);
        check("t5.nv_vec", irqVector, 32'h20);
        ack = 1; tick(); ack = 0;
        eoi = 1; tick(); eoi = 0;

        // reset during nested service
        req = 1; num = 4; tick(); req = 0;
        ack = 1; tick(); ack = 0;
        check("t6.vclr", 32'(vClear), 32'h0010);
        req = 1; isNv = 1; tick(); req = 0; isNv = 0;
        ack = 1; tick(); ack = 0;
        tick();
        rst = 1; tick(); rst = 0;
        checkIdle("t6.rst");
        tick();
        checkIdle("t6.after");
        // reset together with ack suppresses the clear pulse
        req = 1; num = 6; tick(); req = 0;
        ack = 1; rst = 1; tick(); ack = 0; rst = 0;
        checkIdle("t6.rst_ack");
        tick();
        checkIdle("t6.rst_ack2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/irq_entry_sequencer.md
# irq_entry_sequencer

CPU-side consumer of the interrupt arbiter's outputs (`wire_VICIRQRequest`, `wire_IRQArbiter_HandlerNum`, `wire_IRQArbiter_IsnvIRQ`). It runs the interrupt entry handshake with the core, computes the handler vector address, issues one-cycle clear pulses back to the requesting source, and tracks in-service state. It allows one level of nesting: a non-vectored IRQ (nvIRQ) may preempt a vectored IRQ in service.

## Interface
- `VECTOR_BASE`, 32'h0000_0040: base address of the vectored handler table.
- `STRIDE_LOG2`, 2: log2 of the table entry size in bytes.
- `NV_VECTOR`, 32'h0000_0020: handler address for nvIRQ.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `wire_VICIRQRequest`  in  1  arbiter: an interrupt is pending.
- `wire_IRQArbiter_HandlerNum`  in  4  arbiter: number of the winning vectored source.
- `wire_IRQArbiter_IsnvIRQ`  in  1  arbiter: the pending request is nvIRQ.
- `cpu_irq_enable`  in  1  global interrupt enable from the core.
- `cpu_ack`  in  1  core has accepted the entry (PC saved, pipeline flushed).
- `cpu_eoi`  in  1  core signals end of interrupt (return).
- `irq_take`  out  1  request to the core to enter a handler.
- `irq_vector`  out  32  handler address; valid while `irq_take`=1.
- `vIRQClear`  out  16  one-hot, one-cycle clear pulse to a vectored source.
- `nvIRQClear`  out  1  one-cycle clear pulse to the nvIRQ source.
- `in_service`  out  1  a handler is running.
- `in_service_nv`  out  1  the running handler is nvIRQ.
- `active_num`  out  4  number of the vectored handler that is running or suspended.

## Operation
- State machine states: IDLE, TAKE, SERVICE.
- Context registers:
  - `cur_nv` and `cur_num` hold the current handler.
  - `nest_valid` and `saved_num` hold the suspended vectored handler.
- IDLE:
  - When `wire_VICIRQRequest` & `cpu_irq_enable`: latch `cur_nv`=IsnvIRQ and `cur_num`=HandlerNum, then go to TAKE.
  - Otherwise stay in IDLE.
- TAKE:
  - `irq_take`=1.
  - `irq_vector` comes from the latched context only. Arbiter changes during TAKE are ignored.
  - On `cpu_ack`: go to SERVICE. Next cycle, pulse `nvIRQClear` if `cur_nv`, else pulse `vIRQClear[cur_num]`.
- SERVICE, vectored handler (`cur_nv`=0):
  - When `wire_VICIRQRequest` & IsnvIRQ & `cpu_irq_enable`: set `nest_valid`=1, `saved_num`=`cur_num`, `cur_nv`=1, then go to TAKE.
  - Further vectored requests are ignored.
- SERVICE, nvIRQ handler: nothing preempts it.
- `cpu_eoi` in SERVICE:
  - If `nest_valid`=1: restore `cur_nv`=0 and `cur_num`=`saved_num`, clear `nest_valid`, stay in SERVICE. No clear pulse is issued.
  - Otherwise go to IDLE.
- Vector arithmetic:
  - nvIRQ: `NV_VECTOR`.
  - Vectored: `VECTOR_BASE + ({28'b0,cur_num} << STRIDE_LOG2)`, truncated to 32 bits (wraps).
- Ignored events: `cpu_ack` outside TAKE, and `cpu_eoi` outside SERVICE.
- Simultaneous events:
  - `cpu_eoi` together with an nvIRQ request in vectored SERVICE: the eoi is processed. If the state then becomes IDLE, the nvIRQ is taken from IDLE on the next cycle.
  - `cpu_ack` and `cpu_eoi` together in TAKE: only the ack is processed.
- Output decode:
  - `in_service`=1 in SERVICE, and also in TAKE when `nest_valid`=1.
  - `in_service_nv`=`cur_nv` & (state==SERVICE).
  - `active_num` = `saved_num` if `nest_valid`, else `cur_num`.

## Timing
- All outputs are registered or decoded from registered state; there are no combinational paths from input to output.
- Reset values: state=IDLE, `nest_valid`=0, `irq_take`=0, `irq_vector`=0, `vIRQClear`=0, `nvIRQClear`=0, `in_service`=0, `in_service_nv`=0, `active_num`=0.
- Request sampled at edge N in IDLE: `irq_take`=1 and `irq_vector` valid from N+1.
- `cpu_ack` sampled at edge M:
  - `irq_take`=0 and `in_service`=1 from M+1.
  - The clear pulse is high for exactly the cycle M+1 to M+2.
- `cpu_eoi` sampled at edge K with no nest: `in_service`=0 from K+1. A new request can be sampled at K+1, giving `irq_take` at K+2.
- Nested preemption sampled at edge P: `irq_take`=1 from P+1 with `irq_vector`=`NV_VECTOR`; `in_service` stays 1.
- `rst` asserted mid-operation: all state returns to IDLE on the next edge and the context is discarded. No clear pulse is emitted in that cycle or after it.
- `cpu_irq_enable` is sampled only in IDLE and for preemption. Deasserting it in TAKE or SERVICE does not abort the sequence.

## Test plan
- Reset, then HandlerNum=5 with a vectored request; `cpu_ack` 3 cycles after `irq_take` -> `irq_vector`=32'h54, `vIRQClear`=16'h0020 for one cycle, `in_service`=1, `active_num`=5.
- nvIRQ request from IDLE -> `irq_vector`=32'h20; after ack, `nvIRQClear` pulses once and `in_service_nv`=1; a vectored request during service produces no `irq_take`.
- Vectored 8 in service, then nvIRQ arrives -> `irq_take` with vector 32'h20 and `active_num`=8. After ack, `nvIRQClear` pulses. First eoi -> `in_service_nv`=0 while `in_service` stays 1 with `active_num`=8. Second eoi -> `in_service`=0.
- HandlerNum changes 3->9 while in TAKE -> `irq_vector` stays 32'h4C and the clear pulse targets bit 3.
- `cpu_irq_enable`=0 with a request pending for 10 cycles -> `irq_take` stays 0. Raising enable -> `irq_take` on the following cycle.
- `rst` pulsed during SERVICE with `nest_valid`=1 -> all outputs 0 next cycle, and no clear pulse is emitted.
